// File: rtl/rd_select_multi.sv
// Multi-lane 8b/10b running-disparity selector with a valid/ready output stage,
// RD preload, disparity-violation detection and PMA enable sequencing.
module rd_select_multi #(
   parameter int SYMS    = 2,
   parameter bit INIT_RD = 1'b0,
   parameter int ERR_W   = 8
) (
   input  logic                 Bit_Rate_10,
   input  logic                 Rst,
   input  logic                 enable,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [10*SYMS-1:0]   data_neg,
   input  logic [10*SYMS-1:0]   data_pos,
   input  logic                 rd_load,
   input  logic                 rd_val,
   input  logic                 out_ready,
   output logic [10*SYMS-1:0]   Data_10,
   output logic                 out_valid,
   output logic                 enable_PMA,
   output logic                 rd_state,
   output logic                 disp_err,
   output logic [ERR_W-1:0]     err_cnt,
   output logic [1:0]           state_dbg
);

   // Handshake: a word moves when the sender holds in_valid and in_ready is high
   // in the same cycle; the output word is taken when out_valid & out_ready.
   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [10*SYMS-1:0]  data_q, data_d;
   logic                out_valid_q, out_valid_d;
   logic                disp_err_q, disp_err_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic                rd_q, rd_d;

   logic [SYMS:0]       rd_chain;
   logic [SYMS-1:0]     lane_viol;
   logic [10*SYMS-1:0]  sel_word;
   logic [3:0]          ones;
   logic                accept;

   // Each lane's RD comes from the previous lane's chosen symbol weight.
   always_comb begin
      rd_chain    = '0;
      lane_viol   = '0;
      sel_word    = '0;
      ones        = '0;
      rd_chain[0] = rd_q;
      for (int i = 0; i < SYMS; i++) begin
         sel_word[i*10 +: 10] = rd_chain[i] ? data_pos[i*10 +: 10] : data_neg[i*10 +: 10];
         ones = '0;
         for (int b = 0; b < 10; b++) begin
            ones = ones + {3'b000, sel_word[i*10 + b]};
         end
         lane_viol[i]  = !((ones == 4'd5) ||
                           (ones == 4'd6 && !rd_chain[i]) ||
                           (ones == 4'd4 &&  rd_chain[i]));
         rd_chain[i+1] = (ones == 4'd5) ? rd_chain[i] : (ones > 4'd5);
      end
   end

   assign in_ready = enable & ~rd_load & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      data_d      = data_q;
      out_valid_d = out_valid_q;
      disp_err_d  = 1'b0;
      err_cnt_d   = err_cnt_q;
      rd_d        = rd_q;
      if (accept) begin
         data_d      = sel_word;
         out_valid_d = 1'b1;
         disp_err_d  = |lane_viol;
         rd_d        = rd_chain[SYMS];
         if (|lane_viol && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      // rd_load forces in_ready low, so it never collides with an accept.
      if (rd_load) begin
         rd_d = rd_val;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:   if (accept) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)            state_d = ST_RUN;
            else if (!out_valid_q) state_d = ST_OFF;
         end
         default:  state_d = ST_OFF;
      endcase
   end

   always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
      if (!Rst) begin
         state_q     <= ST_OFF;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         disp_err_q  <= 1'b0;
         err_cnt_q   <= '0;
         rd_q        <= INIT_RD;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         disp_err_q  <= disp_err_d;
         err_cnt_q   <= err_cnt_d;
         rd_q        <= rd_d;
      end
   end

   assign Data_10    = data_q;
   assign out_valid  = out_valid_q;
   assign enable_PMA = (state_q != ST_OFF);
   assign rd_state   = rd_q;
   assign disp_err   = disp_err_q;
   assign err_cnt    = err_cnt_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_rd_select_multi.sv
// Self-checking bench for rd_select_multi: directed scenarios plus random traffic
// compared against a transaction-level disparity model and an expected-word queue.
module tb_rd_select_multi;

   localparam int SYMS  = 2;
   localparam int W     = 10 * SYMS;
   localparam int ERR_W = 8;
   localparam int CMAX  = (1 << ERR_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             enable, in_valid, in_ready, rd_load, rd_val, out_ready;
   logic [W-1:0]     data_neg, data_pos, data_10;
   logic             out_valid, enable_pma, rd_state, disp_err;
   logic [ERR_W-1:0] err_cnt;
   logic [1:0]       state_dbg;

   rd_select_multi #(.SYMS(SYMS), .INIT_RD(1'b0), .ERR_W(ERR_W)) dut (
      .Bit_Rate_10 (clk),
      .Rst         (rst_n),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_neg    (data_neg),
      .data_pos    (data_pos),
      .rd_load     (rd_load),
      .rd_val      (rd_val),
      .out_ready   (out_ready),
      .Data_10     (data_10),
      .out_valid   (out_valid),
      .enable_PMA  (enable_pma),
      .rd_state    (rd_state),
      .disp_err    (disp_err),
      .err_cnt     (err_cnt),
      .state_dbg   (state_dbg)
   );

   // ---------------- scoreboard / model ----------------
   int n_vec  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   logic [W-1:0] m_data;
   bit           m_valid, m_rd, m_err;
   int           m_cnt;
   bit           m_pma_on;   // PMA enabled
   bit           m_draining; // enable dropped, waiting for the held word to leave

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Disparity rules straight from the symbol weight: 5 is neutral, 6 only from
   // RD-, 4 only from RD+; anything else is an error and RD follows the weight.
   function automatic void ref_word(input bit rd_in, input logic [W-1:0] neg, input logic [W-1:0] pos,
                                    output logic [W-1:0] word, output bit rd_out, output bit bad);
      bit rd;
      rd   = rd_in;
      bad  = 1'b0;
      word = '0;
      for (int i = 0; i < SYMS; i++) begin
         logic [9:0] s;
         int n;
         s = rd ? pos[i*10 +: 10] : neg[i*10 +: 10];
         word[i*10 +: 10] = s;
         n = $countones(s);
         if (n == 5) begin
         end else if (n == 6 && rd == 1'b0) begin
            rd = 1'b1;
         end else if (n == 4 && rd == 1'b1) begin
            rd = 1'b0;
         end else begin
            bad = 1'b1;
            rd  = (n > 5);
         end
      end
      rd_out = rd;
   endfunction

   task automatic model_reset();
      m_data = '0; m_valid = 0; m_rd = 0; m_err = 0; m_cnt = 0;
      m_pma_on = 0; m_draining = 0;
      exp_q.delete();
   endtask

   task automatic check_outs(input string pfx);
      check({pfx, "_data"},  data_10,    m_data);
      check({pfx, "_valid"}, out_valid,  m_valid);
      check({pfx, "_derr"},  disp_err,   m_err);
      check({pfx, "_cnt"},   err_cnt,    m_cnt);
      check({pfx, "_rd"},    rd_state,   m_rd);
      check({pfx, "_pma"},   enable_pma, m_pma_on);
   endtask

   // ---------------- driver ----------------
   // Caller sets inputs at the falling edge; this advances one clock and checks.
   task automatic do_cycle(input string pfx);
      bit ready, acc, nrd, bad;
      logic [W-1:0] w;
      #1;
      ready = enable && !rd_load && (!m_valid || out_ready);
      check({pfx, "_in_ready"}, in_ready, ready);
      acc = in_valid && ready;
      ref_word(m_rd, data_neg, data_pos, w, nrd, bad);
      if (m_valid && out_ready) begin
         if (exp_q.size() > 0) begin
            check({pfx, "_taken"}, data_10, exp_q.pop_front());
         end else begin
            n_vec++; n_fail++;
            $display("FAIL %s_taken: got %0h expected no word at %0t", pfx, data_10, $time);
         end
      end
      if (!m_pma_on) begin
         if (acc) m_pma_on = 1;
      end else if (!m_draining) begin
         if (!enable) m_draining = 1;
      end else begin
         if (enable) m_draining = 0;
         else if (!m_valid) begin m_draining = 0; m_pma_on = 0; end
      end
      if (acc) begin
         m_data = w; m_valid = 1; exp_q.push_back(w);
      end else if (out_ready) begin
         m_valid = 0;
      end
      m_err = acc && bad;
      if (acc && bad && m_cnt < CMAX) m_cnt++;
      if (rd_load) m_rd = rd_val;
      else if (acc) m_rd = nrd;
      @(posedge clk);
      @(negedge clk);
      check_outs(pfx);
   endtask

   task automatic mid_reset(input string pfx);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs(pfx);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      enable = 0; in_valid = 0; rd_load = 0; rd_val = 0; out_ready = 1;
      data_neg = '0; data_pos = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outs("rst");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      enable = 1;
      do_cycle("idle");

      // K28.5 on both lanes starting from RD-
      in_valid = 1;
      data_neg = {2{10'b0011111010}};
      data_pos = {2{10'b1100000101}};
      do_cycle("k285");
      check("k285_word", data_10, 20'b1100000101_0011111010);
      check("k285_rd", rd_state, 1'b0);
      check("k285_pma", enable_pma, 1'b1);

      // preload RD+, then a neutral word must take the RD+ candidates
      in_valid = 0; rd_load = 1; rd_val = 1;
      do_cycle("load1");
      rd_load = 0; in_valid = 1;
      data_pos = {2{10'b1010101010}};
      data_neg = {2{10'b0101010101}};
      do_cycle("d215");
      check("d215_word", data_10, {2{10'b1010101010}});
      check("d215_rd", rd_state, 1'b1);
      check("d215_cnt", err_cnt, 8'd0);

      // backpressure: held word must stay, nothing lost afterwards
      out_ready = 0;
      data_pos = {2{10'b1010100011}};
      data_neg = {2{10'b0101011100}};
      do_cycle("stall_a");
      for (int k = 0; k < 3; k++) do_cycle("stall");
      out_ready = 1;
      do_cycle("release");
      do_cycle("release2");

      // load with in_valid high: no transfer that cycle
      rd_load = 1; rd_val = 1; in_valid = 1;
      do_cycle("ld_race");
      rd_load = 0; in_valid = 0;
      do_cycle("ld_after");

      // drain with a held word, re-enable in DRAIN, then drain to OFF
      in_valid = 1; out_ready = 0;
      do_cycle("dr_fill");
      in_valid = 0; enable = 0;
      do_cycle("dr_a");
      do_cycle("dr_b");
      enable = 1;
      do_cycle("dr_back");
      enable = 0;
      do_cycle("dr_c");
      out_ready = 1;
      for (int k = 0; k < 3; k++) do_cycle("dr_off");
      check("dr_pma_off", enable_pma, 1'b0);

      // reset while words are flowing
      enable = 1; in_valid = 1;
      do_cycle("pre_rst");
      mid_reset("midrst");

      // violation: lane 0 heavy at RD-, lane 1 then chosen from RD+
      enable = 1; in_valid = 1; out_ready = 1;
      data_neg = {10'b0101010101, 10'b1111111100};
      data_pos = {10'b1010101010, 10'b1111111100};
      do_cycle("viol1");
      check("viol1_word", data_10, 20'b1010101010_1111111100);
      check("viol1_derr", disp_err, 1'b1);
      check("viol1_cnt", err_cnt, 8'd1);
      for (int k = 0; k < 299; k++) do_cycle("viol");
      in_valid = 0;
      do_cycle("viol_end");
      check("sat_cnt", err_cnt, 8'd255);
      check("sat_derr", disp_err, 1'b0);

      // random traffic
      mid_reset("rrst");
      for (int k = 0; k < 400; k++) begin
         enable    = ($urandom_range(0, 9) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         rd_load   = ($urandom_range(0, 19) == 0);
         rd_val    = 1'($urandom_range(0, 1));
         for (int i = 0; i < SYMS; i++) begin
            logic [9:0] s;
            s = 10'($urandom_range(0, 1023));
            data_neg[i*10 +: 10] = s;
            data_pos[i*10 +: 10] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : ~s;
         end
         do_cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/rd_select_multi.md
Name: rd_select_multi

Overview:
- Parametrised successor to the single-symbol running-disparity (RD) selector in the TX PCS.
- Accepts SYMS pre-encoded 8b/10b symbol pairs per word, each pair being an RD- candidate and an RD+ candidate.
- For each lane it picks the candidate matching the true running disparity, computed from the chosen symbol's ones-count, not by blind toggling.
- Adds a valid/ready handshake toward the PMA serializer, an RD preload, disparity-error detection and a saturating error counter.

Parameters:
SYMS, 2, symbols per input word; lane 0 is transmitted first (bits [9:0]).
INIT_RD, 0, RD after reset (0 = RD-, 1 = RD+).
ERR_W, 8, width of the saturating disparity-error counter.

Ports:
Bit_Rate_10  in   1          word clock.
Rst          in   1          asynchronous, active-low reset.
enable       in   1          block enable; low = no new transfers, RD held.
in_valid     in   1          input word valid.
in_ready     out  1          block can accept a word this cycle.
data_neg     in   10*SYMS    per-lane RD- candidates.
data_pos     in   10*SYMS    per-lane RD+ candidates.
rd_load      in   1          synchronous RD preload strobe.
rd_val       in   1          value loaded when rd_load is high.
out_ready    in   1          PMA accepts Data_10.
Data_10      out  10*SYMS    selected symbols, registered.
out_valid    out  1          Data_10 holds an untaken word.
enable_PMA   out  1          PMA serializer enable.
rd_state     out  1          current RD (value for the next word's lane 0).
disp_err     out  1          1-cycle pulse, registered with the word containing a violation.
err_cnt      out  ERR_W      saturating count of words with a violation.

Behaviour:
Reset (Rst low, asynchronous):
- Data_10=0, out_valid=0, enable_PMA=0, disp_err=0, err_cnt=0, rd_state=INIT_RD.

Handshake:
- in_ready = enable & !rd_load & (!out_valid | out_ready).
- Accept when in_valid & in_ready: Data_10, disp_err and rd_state update on the next edge, giving 1-cycle latency.
- out_valid: set on accept; cleared when out_ready & !accept.
- With out_ready=0, Data_10 and out_valid hold stable.

Per-lane RD chain (combinational, lane 0..SYMS-1):
- r0 = rd_state.
- Lane i selects data_neg[i] if r_i=0, else data_pos[i].
- n = ones-count of the selected symbol (0..10).
- n=5: r_{i+1}=r_i, legal.
- n=6 with r_i=0: r_{i+1}=1, legal.
- n=4 with r_i=1: r_{i+1}=0, legal.
- Any other n (n=6 at RD+, n=4 at RD-, n<=3, n>=7) is a violation. RD is then recomputed as: n>5 gives 1, n<5 gives 0.
- r_SYMS is written to rd_state on accept.

Errors:
- disp_err=1 for the accepted word if any lane violated; otherwise 0.
- disp_err clears to 0 on the next edge if no accept occurs.
- err_cnt increments by 1 per violating word, regardless of how many lanes violated, and saturates at 2^ERR_W-1.

RD preload:
- rd_load high: rd_state<=rd_val; in_ready forced 0, so no transfer can race the load.
- Load works with enable low.

State machine (registered):
- OFF: enable_PMA=0. Go to RUN on the first accept.
- RUN: enable_PMA=1. Go to DRAIN when enable falls.
- DRAIN: enable_PMA=1 until out_valid clears, then OFF. enable rising again in DRAIN returns to RUN.
- rd_state is retained across OFF/DRAIN; only Rst or rd_load changes it outside accepts.

Other boundary conditions:
- Reset mid-transfer discards the held word.
- Simultaneous accept and out_ready: the new word replaces the old one and out_valid stays 1.

Test Plan:
1. Rst low then released, INIT_RD=0 -> all outputs 0, rd_state=0, in_ready=1 once enable=1.
2. SYMS=2, both lanes data_neg=0011111010, data_pos=1100000101 (K28.5), out_ready=1 -> next cycle Data_10 = {1100000101, 0011111010}, rd_state=0, disp_err=0, enable_PMA=1.
3. Both lanes 1010101010 (D21.5, neutral), rd_state=1 -> both lanes take data_pos, rd_state stays 1, err_cnt unchanged.
4. out_ready=0 for 3 cycles with in_valid=1 -> Data_10 and out_valid stable, in_ready=0. Release -> next word appears 1 cycle later with no word lost.
5. Lane 0 data_neg=1111111100 at RD- -> disp_err pulse, err_cnt 0->1, lane 1 evaluated at RD+. Force 300 such words with ERR_W=8 -> err_cnt sticks at 255.
6. rd_load=1, rd_val=1 with in_valid=1 -> no accept that cycle, rd_state=1. Then drop enable -> DRAIN, then OFF after out_valid clears, rd_state retained. Assert Rst mid-stream -> immediate reset values.
